// File: rtl/stopwatch_uart_tx_report.sv
// Formats a stopwatch snapshot as "HH:MM:SS.CC\r\n" and streams it to a UART transmitter.
// Optional macro STATUS_CHAR_EN prefixes the frame with a run-state character and a space.
module stopwatch_uart_tx_report #(
    parameter int unsigned AUTO_PERIOD = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    input  logic       i_runstop,
    input  logic       i_clear,
    input  logic       i_send,
    input  logic       i_tx_busy,
    input  logic       i_tx_done,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic       o_busy,
    output logic       o_frame_done
);

`ifdef STATUS_CHAR_EN
    localparam logic [3:0] OFF = 4'd2;
`else
    localparam logic [3:0] OFF = 4'd0;
`endif
    localparam logic [3:0]  LAST      = OFF + 4'd12;
    localparam bit          AUTO_EN   = (AUTO_PERIOD != 32'd0);
    localparam logic [31:0] AUTO_LAST = AUTO_EN ? (AUTO_PERIOD - 32'd1) : 32'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  idx_q;
    logic        pending_q;
    logic [6:0]  msec_q;
    logic [5:0]  sec_q;
    logic [5:0]  min_q;
    logic [4:0]  hour_q;
    logic [31:0] auto_cnt_q;
    logic [31:0] auto_cnt_d;
    logic [7:0]  o_tx_data_q;
    logic        o_tx_start_q;
    logic        o_busy_q;
    logic        o_frame_done_q;

    logic        auto_tick_s;
    logic        new_req_s;
    logic        req_s;
    logic [15:0] hh_s;
    logic [15:0] mm_s;
    logic [15:0] ss_s;
    logic [15:0] cc_s;
    logic [7:0]  char_s;

    // Two ASCII digits of a value, saturating anything above 99 to "99".
    function automatic logic [15:0] to_ascii2(input logic [6:0] v);
        logic [6:0] sat;
        logic [6:0] tens;
        logic [6:0] ones;
        sat  = (v > 7'd99) ? 7'd99 : v;
        tens = sat / 7'd10;
        ones = sat - tens * 7'd10;
        return {8'h30 + {1'b0, tens}, 8'h30 + {1'b0, ones}};
    endfunction

`ifdef STATUS_CHAR_EN
    logic [7:0] status_q;
    logic [7:0] status_d;

    // Run state wins over clear; otherwise the stopwatch is stopped.
    always_comb begin
        if (i_runstop) begin
            status_d = 8'h52;
        end else if (i_clear) begin
            status_d = 8'h43;
        end else begin
            status_d = 8'h53;
        end
    end
`else
    logic unused_status_s;
    assign unused_status_s = i_runstop | i_clear;
`endif

    assign auto_tick_s = AUTO_EN && (auto_cnt_q == AUTO_LAST);
    assign new_req_s   = i_send | auto_tick_s;
    assign req_s       = new_req_s | pending_q;

    // Free-running auto-report counter, held at zero when periodic reports are disabled.
    always_comb begin
        if (!AUTO_EN) begin
            auto_cnt_d = 32'd0;
        end else if (auto_tick_s) begin
            auto_cnt_d = 32'd0;
        end else begin
            auto_cnt_d = auto_cnt_q + 32'd1;
        end
    end

    // Auto-report counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_cnt_q <= 32'd0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end

    // Character selected by the current byte index of the snapshot.
    always_comb begin
        hh_s   = to_ascii2({2'b00, hour_q});
        mm_s   = to_ascii2({1'b0, min_q});
        ss_s   = to_ascii2({1'b0, sec_q});
        cc_s   = to_ascii2(msec_q);
        char_s = 8'h00;
        case (idx_q)
`ifdef STATUS_CHAR_EN
            4'd0:         char_s = status_q;
            4'd1:         char_s = 8'h20;
`endif
            OFF + 4'd0:   char_s = hh_s[15:8];
            OFF + 4'd1:   char_s = hh_s[7:0];
            OFF + 4'd2:   char_s = 8'h3A;
            OFF + 4'd3:   char_s = mm_s[15:8];
            OFF + 4'd4:   char_s = mm_s[7:0];
            OFF + 4'd5:   char_s = 8'h3A;
            OFF + 4'd6:   char_s = ss_s[15:8];
            OFF + 4'd7:   char_s = ss_s[7:0];
            OFF + 4'd8:   char_s = 8'h2E;
            OFF + 4'd9:   char_s = cc_s[15:8];
            OFF + 4'd10:  char_s = cc_s[7:0];
            OFF + 4'd11:  char_s = 8'h0D;
            OFF + 4'd12:  char_s = 8'h0A;
            default:      char_s = 8'h00;
        endcase
    end

    // Frame sequencer; requests arriving mid-frame collapse into one pending frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            idx_q          <= 4'd0;
            pending_q      <= 1'b0;
            msec_q         <= 7'd0;
            sec_q          <= 6'd0;
            min_q          <= 6'd0;
            hour_q         <= 5'd0;
`ifdef STATUS_CHAR_EN
            status_q       <= 8'h00;
`endif
            o_tx_data_q    <= 8'h00;
            o_tx_start_q   <= 1'b0;
            o_busy_q       <= 1'b0;
            o_frame_done_q <= 1'b0;
        end else begin
            o_tx_start_q   <= 1'b0;
            o_frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_s) begin
                        msec_q    <= i_msec;
                        sec_q     <= i_sec;
                        min_q     <= i_min;
                        hour_q    <= i_hour;
`ifdef STATUS_CHAR_EN
                        status_q  <= status_d;
`endif
                        idx_q     <= 4'd0;
                        pending_q <= 1'b0;
                        o_busy_q  <= 1'b1;
                        state_q   <= S_SEND;
                    end
                end
                S_SEND: begin
                    pending_q <= pending_q | new_req_s;
                    if (!i_tx_busy) begin
                        o_tx_data_q  <= char_s;
                        o_tx_start_q <= 1'b1;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    pending_q <= pending_q | new_req_s;
                    if (i_tx_done) begin
                        if (idx_q == LAST) begin
                            o_busy_q       <= 1'b0;
                            o_frame_done_q <= 1'b1;
                            state_q        <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= S_SEND;
                        end
                    end
                end
                default: begin
                    pending_q <= 1'b0;
                    o_busy_q  <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx_data    = o_tx_data_q;
    assign o_tx_start   = o_tx_start_q;
    assign o_busy       = o_busy_q;
    assign o_frame_done = o_frame_done_q;

endmodule

// File: tb/tb_stopwatch_uart_tx_report.sv
// Directed bench: one instance without auto reports (slow UART model) and one with
// AUTO_PERIOD=50 (fast UART model). Expected frames are written out by hand below.
module tb_stopwatch_uart_tx_report;

`ifdef STATUS_CHAR_EN
    localparam int         FL         = 15;
    localparam string      PR         = "R ";
    localparam string      PC         = "C ";
    localparam string      PS         = "S ";
    localparam logic [7:0] FIRST_HOLD = 8'h43;
`else
    localparam int         FL         = 13;
    localparam string      PR         = "";
    localparam string      PC         = "";
    localparam string      PS         = "";
    localparam logic [7:0] FIRST_HOLD = 8'h31;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min_v;
    logic [4:0] hour;
    logic       runstop;
    logic       clear_v;
    logic       send;
    logic       hold_busy;

    logic       busy_m0 = 1'b0;
    logic       done0 = 1'b0;
    logic [7:0] data0;
    logic       start0;
    logic       obusy0;
    logic       fdone0;
    logic       busy_mA = 1'b0;
    logic       doneA = 1'b0;
    logic [7:0] dataA;
    logic       startA;
    logic       obusyA;
    logic       fdoneA;

    int cnt0 = 0;
    int cntA = 0;
    int starts0 = 0;
    int startsA = 0;
    int frames0 = 0;
    int cyc = 0;
    int nA = 0;
    int fs [8];
    logic [7:0] bytes0 [$];
    logic [7:0] bytesA [$];

    int n_assert = 0;
    int n_fail = 0;

    stopwatch_uart_tx_report #(.AUTO_PERIOD(0)) dut (
        .clk(clk), .rst(rst),
        .i_msec(msec), .i_sec(sec), .i_min(min_v), .i_hour(hour),
        .i_runstop(runstop), .i_clear(clear_v), .i_send(send),
        .i_tx_busy(busy_m0 | hold_busy), .i_tx_done(done0),
        .o_tx_data(data0), .o_tx_start(start0), .o_busy(obusy0), .o_frame_done(fdone0)
    );

    stopwatch_uart_tx_report #(.AUTO_PERIOD(50)) dut_a (
        .clk(clk), .rst(rst),
        .i_msec(7'd10), .i_sec(6'd9), .i_min(6'd8), .i_hour(5'd7),
        .i_runstop(1'b0), .i_clear(1'b1), .i_send(1'b0),
        .i_tx_busy(busy_mA), .i_tx_done(doneA),
        .o_tx_data(dataA), .o_tx_start(startA), .o_busy(obusyA), .o_frame_done(fdoneA)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Slow UART: done pulse 10 clk after each start.
    always @(negedge clk) begin
        if (!rst) begin
            cnt0 = 0; busy_m0 = 1'b0; done0 = 1'b0;
        end else begin
            done0 = 1'b0;
            if (cnt0 != 0) begin
                cnt0 = cnt0 - 1;
                if (cnt0 == 0) begin done0 = 1'b1; busy_m0 = 1'b0; end
            end
            if (start0) begin
                bytes0.push_back(data0);
                starts0 = starts0 + 1;
                busy_m0 = 1'b1;
                cnt0 = 10;
            end
            if (fdone0) frames0 = frames0 + 1;
        end
    end

    // Fast UART: done pulse 1 clk after each start; logs the cycle of every frame's first byte.
    always @(negedge clk) begin
        if (!rst) begin
            cntA = 0; busy_mA = 1'b0; doneA = 1'b0;
        end else begin
            doneA = 1'b0;
            if (cntA != 0) begin
                cntA = cntA - 1;
                if (cntA == 0) begin doneA = 1'b1; busy_mA = 1'b0; end
            end
            if (startA) begin
                if ((startsA % FL) == 0 && nA < 8) begin fs[nA] = cyc; nA = nA + 1; end
                bytesA.push_back(dataA);
                startsA = startsA + 1;
                busy_mA = 1'b1;
                cntA = 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input int base, input string t, input bit use_a);
        logic [7:0] got;
        for (int i = 0; i < t.len() + 2; i++) begin
            got = use_a ? bytesA[base + i] : bytes0[base + i];
            if (i < t.len()) chk(tag, {24'd0, got}, {24'd0, t.getc(i)});
            else if (i == t.len()) chk(tag, {24'd0, got}, 32'h0D);
            else chk(tag, {24'd0, got}, 32'h0A);
        end
    endtask

    task automatic wait_frames0(input int target, input int budget);
        int t = 0;
        while (frames0 < target && t < budget) begin @(negedge clk); t++; end
        chk("frame_wait", frames0, target);
    endtask

    task automatic pulse_send();
        @(negedge clk); send = 1'b1;
        @(negedge clk); send = 1'b0;
    endtask

    initial begin
        int t;
        rst = 1'b0; send = 1'b0; hold_busy = 1'b0; runstop = 1'b0; clear_v = 1'b0;
        hour = 5'd0; min_v = 6'd0; sec = 6'd0; msec = 7'd0;
        repeat (3) @(negedge clk);
        chk("rst_data", data0, 8'h00);
        chk("rst_start", start0, 1'b0);
        chk("rst_busy", obusy0, 1'b0);
        chk("rst_fdone", fdone0, 1'b0);
        rst = 1'b1;

        // Basic frame and first-start latency
        hour = 5'd1; min_v = 6'd2; sec = 6'd3; msec = 7'd45; runstop = 1'b1;
        @(negedge clk); send = 1'b1;
        @(negedge clk); send = 1'b0;
        chk("req_busy", obusy0, 1'b1);
        chk("req_no_start", start0, 1'b0);
        @(negedge clk);
        chk("first_start", start0, 1'b1);
        wait_frames0(1, 400);
        chk("f1_starts", starts0, FL);
        chk("f1_idle", obusy0, 1'b0);
        @(negedge clk);
        chk("fdone_pulse", fdone0, 1'b0);
        check_frame("f1_byte", 0, {PR, "01:02:03.45"}, 1'b0);

        // Auto reports every 50 clk on the second instance
        t = 0;
        while (nA < 4 && t < 1000) begin @(negedge clk); t++; end
        chk("auto_count", nA >= 4, 1'b1);
        chk("auto_gap1", fs[1] - fs[0], 50);
        chk("auto_gap2", fs[2] - fs[1], 50);
        chk("auto_gap3", fs[3] - fs[2], 50);
        check_frame("auto_byte", 0, {PC, "07:08:09.10"}, 1'b1);

        // UART busy at request holds the first start
        runstop = 1'b0; clear_v = 1'b1;
        hour = 5'd12; min_v = 6'd34; sec = 6'd56; msec = 7'd78;
        hold_busy = 1'b1;
        pulse_send();
        repeat (20) @(negedge clk);
        chk("hold_no_start", starts0, FL);
        chk("hold_busy", obusy0, 1'b1);
        hold_busy = 1'b0;
        @(negedge clk);
        chk("hold_release_start", start0, 1'b1);
        chk("hold_release_data", data0, FIRST_HOLD);
        wait_frames0(2, 400);
        check_frame("f2_byte", FL, {PC, "12:34:56.78"}, 1'b0);

        // Repeated requests mid-frame with changing inputs
        clear_v = 1'b0;
        hour = 5'd5; min_v = 6'd6; sec = 6'd7; msec = 7'd8;
        pulse_send();
        repeat (30) @(negedge clk);
        hour = 5'd23; min_v = 6'd45; sec = 6'd63; msec = 7'd120; runstop = 1'b1;
        repeat (3) begin
            pulse_send();
            repeat (5) @(negedge clk);
        end
        wait_frames0(4, 1000);
        check_frame("f3_byte", 2 * FL, {PS, "05:06:07.08"}, 1'b0);
        check_frame("f4_byte", 3 * FL, {PR, "23:45:63.99"}, 1'b0);
        repeat (300) @(negedge clk);
        chk("collapse_frames", frames0, 4);
        chk("collapse_starts", starts0, 4 * FL);

        // Reset in the middle of a frame, then 10k idle clk with auto reports disabled
        hour = 5'd0; min_v = 6'd0; sec = 6'd59; msec = 7'd99;
        pulse_send();
        t = 0;
        while (starts0 < 4 * FL + 3 && t < 200) begin @(negedge clk); t++; end
        chk("pre_rst_starts", starts0, 4 * FL + 3);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_data", data0, 8'h00);
        chk("mid_rst_start", start0, 1'b0);
        chk("mid_rst_busy", obusy0, 1'b0);
        chk("mid_rst_fdone", fdone0, 1'b0);
        rst = 1'b1;
        repeat (10000) @(negedge clk);
        chk("post_rst_starts", starts0, 4 * FL + 3);
        chk("post_rst_frames", frames0, 4);
        chk("post_rst_busy", obusy0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
